// File: rtl/b2c_conv_pipe.sv
// b2c_conv_pipe: pipelined converter between two's-complement and sign-magnitude.
// Modes: 00 pass, 01 negate, 10 sign-magnitude to 2C, 11 2C to sign-magnitude.
// The +1 of each negation is spread over STAGES register slices, one chunk per slice.
// Build option B2C_SAT_EN: when defined, overflowing results saturate; otherwise they wrap.
module b2c_conv_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_NEG   = 2'b01,
      MODE_SM2TC = 2'b10,
      MODE_TC2SM = 2'b11
   } mode_t;

   localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

   // The most negative 2C value is the only input that cannot be negated or
   // expressed as a sign-magnitude number of the same width.
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef B2C_SAT_EN
   localparam logic [WIDTH-1:0] OVF_NEG_RES = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] OVF_SM_RES  = {WIDTH{1'b1}};
`else
   localparam logic [WIDTH-1:0] OVF_NEG_RES = MIN_NEG;
   localparam logic [WIDTH-1:0] OVF_SM_RES  = MIN_NEG;
`endif

   // Adds carry c into the bits of chunk k only; bits outside the chunk pass through.
   function automatic logic [WIDTH-1:0] chunk_sum(input logic [WIDTH-1:0] d,
                                                  input logic c, input int k);
      logic [WIDTH-1:0] r;
      logic             cy;
      int               lo;
      int               hi;
      r  = d;
      cy = c;
      lo = k * CHUNK;
      hi = lo + CHUNK;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= lo && i < hi) begin
            r[i] = d[i] ^ cy;
            cy   = d[i] & cy;
         end
      end
      return r;
   endfunction

   // Carry leaving chunk k when carry c enters it (c itself for an empty chunk).
   function automatic logic chunk_cout(input logic [WIDTH-1:0] d,
                                       input logic c, input int k);
      logic cy;
      int   lo;
      int   hi;
      cy = c;
      lo = k * CHUNK;
      hi = lo + CHUNK;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= lo && i < hi) begin
            cy = d[i] & cy;
         end
      end
      return cy;
   endfunction

   logic             en;
   logic [WIDTH-1:0] pre_data;
   logic             pre_carry;
   logic             pre_ovf;

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [STAGES-1:0] ovf_q;
   logic [WIDTH-1:0]  data_q [STAGES];

   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign out_valid = valid_q[STAGES-1];
   assign out_ovf   = ovf_q[STAGES-1] & valid_q[STAGES-1];

   // The final chunk's increment is applied on the way out of the last slice.
   assign out_data  = chunk_sum(data_q[STAGES-1], carry_q[STAGES-1], STAGES-1);

   // Pre-conditioning: choose inversion plus carry-in, or a ready-made overflow result.
   always_comb begin
      pre_data  = in_data;
      pre_carry = 1'b0;
      pre_ovf   = 1'b0;
      case (mode_t'(in_mode))
         MODE_PASS: begin
            pre_data = in_data;
         end
         MODE_NEG: begin
            if (in_data == MIN_NEG) begin
               pre_data = OVF_NEG_RES;
               pre_ovf  = 1'b1;
            end else begin
               pre_data  = ~in_data;
               pre_carry = 1'b1;
            end
         end
         MODE_SM2TC: begin
            if (in_data[WIDTH-1]) begin
               pre_data  = ~{1'b0, in_data[WIDTH-2:0]};
               pre_carry = 1'b1;
            end
         end
         MODE_TC2SM: begin
            if (in_data == MIN_NEG) begin
               pre_data = OVF_SM_RES;
               pre_ovf  = 1'b1;
            end else if (in_data[WIDTH-1]) begin
               // Carry can never reach the sign bit here, so it is preset to 1.
               pre_data  = {1'b1, ~in_data[WIDTH-2:0]};
               pre_carry = 1'b1;
            end
         end
         default: begin
            pre_data = in_data;
         end
      endcase
   end

   // Pipeline slices: all shift together on en, each adding the carry into its chunk.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else if (en) begin
         valid_q[0] <= in_valid;
         data_q[0]  <= pre_data;
         carry_q[0] <= pre_carry & in_valid;
         ovf_q[0]   <= pre_ovf & in_valid;
         for (int k = 1; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
            data_q[k]  <= chunk_sum(data_q[k-1], carry_q[k-1], k-1);
            carry_q[k] <= chunk_cout(data_q[k-1], carry_q[k-1], k-1);
            ovf_q[k]   <= ovf_q[k-1];
         end
      end
   end

endmodule
